// File: rtl/pb_step_ctrl.sv
// Saturating up/down parameter register driven by debounced INC/DEC button pulses,
// with press-to-step, hold-to-auto-repeat and both-buttons reload to INIT_VAL.
module pb_step_ctrl #(
    parameter int WIDTH    = 4,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 15,
    parameter int INIT_VAL = 8,
    parameter int HOLD_CYC = 50000000,
    parameter int REP_CYC  = 10000000,
    parameter int CNT_W    = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_down,
    input  logic             inc_up,
    input  logic             dec_down,
    input  logic             dec_up,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             at_min,
    output logic             at_max
);
    localparam logic [WIDTH-1:0] MINV      = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INITV     = WIDTH'(INIT_VAL);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    typedef enum logic [2:0] {IDLE, INC_WAIT, INC_RPT, DEC_WAIT, DEC_RPT, BOTH} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             inc_held, dec_held, inc_held_nx, dec_held_nx;
    logic [WIDTH-1:0] value_nx, val_up, val_dn;

    assign val_up = (value == MAXV) ? value : value + 1'b1;
    assign val_dn = (value == MINV) ? value : value - 1'b1;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        value_nx    = value;
        // a same-cycle down+up leaves the button released
        inc_held_nx = inc_down ? ~inc_up : (inc_held & ~inc_up);
        dec_held_nx = dec_down ? ~dec_up : (dec_held & ~dec_up);
        case (state)
            IDLE: begin
                if (inc_down && dec_down) begin
                    value_nx = INITV;
                    state_nx = BOTH;
                end else if (inc_down) begin
                    value_nx = val_up;
                    cnt_nx   = '0;
                    state_nx = inc_held_nx ? INC_WAIT : IDLE;
                end else if (dec_down) begin
                    value_nx = val_dn;
                    cnt_nx   = '0;
                    state_nx = dec_held_nx ? DEC_WAIT : IDLE;
                end
            end
            INC_WAIT, INC_RPT: begin
                if (dec_down) begin
                    value_nx = INITV;
                    cnt_nx   = '0;
                    state_nx = BOTH;
                end else if (inc_up) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == ((state == INC_WAIT) ? HOLD_LAST : REP_LAST)) begin
                    value_nx = val_up;
                    cnt_nx   = '0;
                    state_nx = INC_RPT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DEC_WAIT, DEC_RPT: begin
                if (inc_down) begin
                    value_nx = INITV;
                    cnt_nx   = '0;
                    state_nx = BOTH;
                end else if (dec_up) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == ((state == DEC_WAIT) ? HOLD_LAST : REP_LAST)) begin
                    value_nx = val_dn;
                    cnt_nx   = '0;
                    state_nx = DEC_RPT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            BOTH: begin
                if (!inc_held_nx && !dec_held_nx) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            inc_held <= 1'b0;
            dec_held <= 1'b0;
            value    <= INITV;
            changed  <= 1'b0;
            at_min   <= (INITV == MINV);
            at_max   <= (INITV == MAXV);
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            inc_held <= inc_held_nx;
            dec_held <= dec_held_nx;
            value    <= value_nx;
            changed  <= (value_nx != value);
            at_min   <= (value_nx == MINV);
            at_max   <= (value_nx == MAXV);
        end
    end
endmodule

// File: tb/tb_pb_step_ctrl.sv
// Randomized + directed bench for pb_step_ctrl against a press-age based reference model.
`timescale 1ns/1ps
module tb_pb_step_ctrl;
    localparam int WIDTH = 4, MIN_VAL = 0, MAX_VAL = 15, INIT_VAL = 8;
    localparam int HOLD = 8, REP = 4, CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inc_down = 1'b0, inc_up = 1'b0, dec_down = 1'b0, dec_up = 1'b0;
    logic [WIDTH-1:0] value;
    logic             changed, at_min, at_max;

    int total = 0, bad = 0;

    pb_step_ctrl #(
        .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .INIT_VAL(INIT_VAL),
        .HOLD_CYC(HOLD), .REP_CYC(REP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inc_down(inc_down), .inc_up(inc_up), .dec_down(dec_down), .dec_up(dec_up),
        .value(value), .changed(changed), .at_min(at_min), .at_max(at_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 none, 1 inc held, 2 dec held, 3 both; steps derived from press age.
    int m_val, m_mode, m_press, cyc_n;
    bit m_ih, m_dh, m_chg;

    function automatic int sat(input int v);
        return (v > MAX_VAL) ? MAX_VAL : (v < MIN_VAL) ? MIN_VAL : v;
    endfunction

    function automatic bit rpt_hit(input int age);
        return (age >= HOLD) && ((age - HOLD) % REP == 0);
    endfunction

    task automatic m_reset();
        m_val = INIT_VAL; m_mode = 0; m_ih = 0; m_dh = 0; m_chg = 0;
    endtask

    task automatic m_step(input bit id, input bit iu, input bit dd, input bit du);
        int prev;
        prev = m_val;
        m_ih = id ? !iu : (m_ih && !iu);
        m_dh = dd ? !du : (m_dh && !du);
        case (m_mode)
            0: if (id && dd) begin m_val = INIT_VAL; m_mode = 3; end
               else if (id) begin m_val = sat(m_val + 1); m_mode = iu ? 0 : 1; m_press = cyc_n; end
               else if (dd) begin m_val = sat(m_val - 1); m_mode = du ? 0 : 2; m_press = cyc_n; end
            1: if (dd) begin m_val = INIT_VAL; m_mode = 3; end
               else if (iu) m_mode = 0;
               else if (rpt_hit(cyc_n - m_press)) m_val = sat(m_val + 1);
            2: if (id) begin m_val = INIT_VAL; m_mode = 3; end
               else if (du) m_mode = 0;
               else if (rpt_hit(cyc_n - m_press)) m_val = sat(m_val - 1);
            default: if (!m_ih && !m_dh) m_mode = 0;
        endcase
        m_chg = (m_val != prev);
        cyc_n++;
    endtask

    task automatic cyc(input bit id, input bit iu, input bit dd, input bit du);
        @(negedge clk);
        inc_down = id; inc_up = iu; dec_down = dd; dec_up = du;
        m_step(id, iu, dd, du);
        @(posedge clk);
        #1;
        chk("value", value, m_val);
        chk("changed", changed, m_chg);
        chk("at_min", at_min, m_val == MIN_VAL);
        chk("at_max", at_max, m_val == MAX_VAL);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    // Reset asserted mid-cycle; value must return before the next clock edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_value", value, INIT_VAL);
        chk("rst_changed", changed, 0);
        m_reset();
        @(negedge clk);
        inc_down = 0; inc_up = 0; dec_down = 0; dec_up = 0;
        rst_n = 1'b1;
    endtask

    bit id, iu, dd, du, inc_p, dec_p;

    initial begin
        cyc_n = 0;
        m_reset();
        #12;
        chk("reset_value", value, 8);
        chk("reset_changed", changed, 0);
        chk("reset_at_min", at_min, 0);
        chk("reset_at_max", at_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(50);

        // single press/release each way
        cyc(1, 0, 0, 0); idle(2); cyc(0, 1, 0, 0); idle(3);
        cyc(0, 0, 1, 0); idle(2); cyc(0, 0, 0, 1); idle(3);

        // INC held into repeat and saturation, then DEC held down to MIN
        cyc(1, 0, 0, 0); idle(29); cyc(0, 1, 0, 0); idle(3);
        cyc(0, 0, 1, 0); idle(70); cyc(0, 0, 0, 1); idle(3);

        // climb to 12, hold INC, press DEC -> reload, no repeats while both held
        for (int i = 0; i < 12; i++) begin cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); end
        cyc(1, 0, 0, 0); idle(3); cyc(0, 0, 1, 0); idle(12);
        cyc(0, 1, 0, 0); idle(3); cyc(0, 0, 0, 1); idle(2);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 0); idle(2); cyc(0, 1, 0, 1); idle(3);

        // reset while auto-repeating at 11
        cyc(1, 0, 0, 0); idle(14);
        mid_reset();
        cyc(0, 1, 0, 0); idle(2);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(2);

        // random button activity shaped like debouncer output
        inc_p = 0; dec_p = 0;
        for (int i = 0; i < 3000; i++) begin
            id = 0; iu = 0; dd = 0; du = 0;
            if (!inc_p) begin
                if ($urandom_range(0, 14) == 0) begin id = 1; inc_p = 1; end
                else if ($urandom_range(0, 59) == 0) iu = 1;
            end else if ($urandom_range(0, 24) == 0) begin iu = 1; inc_p = 0; end
            if (!dec_p) begin
                if ($urandom_range(0, 14) == 0) begin dd = 1; dec_p = 1; end
                else if ($urandom_range(0, 59) == 0) du = 1;
            end else if ($urandom_range(0, 24) == 0) begin du = 1; dec_p = 0; end
            cyc(id, iu, dd, du);
            if ($urandom_range(0, 599) == 0) begin
                mid_reset();
                inc_p = 0; dec_p = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
